// File: rtl/soc_bus_arbiter_pkg.sv
// Shared encodings for the SoC peripheral bus arbiter: FSM states, master IDs
// and slave slot indices.
package soc_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam logic MST_JTAG = 1'b0;
  localparam logic MST_CPU  = 1'b1;

  localparam int SLV_TIMER = 0;
  localparam int SLV_UART  = 1;
  localparam int SLV_GPIO  = 2;
  localparam int SLV_SPARE = 3;

  // Slave index lives in the top nibble of the address.
  localparam int IDX_W = 4;

  function automatic logic [1:0] mst_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/soc_bus_arbiter_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to whichever
// master did not own the bus last. Purely combinational.
module soc_bus_rr_arbiter
  import soc_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = mst_onehot(~last_owner);
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/soc_bus_arbiter.sv
// Shares the peripheral bus between the JTAG debug port (m0) and the CPU port (m1).
// One transaction in flight; every transaction ends in a response (ack, decode error or timeout).
module soc_bus_arbiter
  import soc_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             m0_req_i,
  input  logic                             m0_we_i,
  input  logic [ADDR_WIDTH-1:0]            m0_addr_i,
  input  logic [DATA_WIDTH-1:0]            m0_wdata_i,
  output logic                             m0_gnt_o,
  output logic                             m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]            m0_rdata_o,
  output logic                             m0_err_o,
  input  logic                             m1_req_i,
  input  logic                             m1_we_i,
  input  logic [ADDR_WIDTH-1:0]            m1_addr_i,
  input  logic [DATA_WIDTH-1:0]            m1_wdata_i,
  output logic                             m1_gnt_o,
  output logic                             m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]            m1_rdata_o,
  output logic                             m1_err_o,
  output logic [NUM_SLAVES-1:0]            s_sel_o,
  output logic                             s_we_o,
  output logic [ADDR_WIDTH-1:0]            s_addr_o,
  output logic [DATA_WIDTH-1:0]            s_wdata_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata_i,
  input  logic [NUM_SLAVES-1:0]            s_ack_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  arb_state_t state_q, state_d;

  logic                  owner_q, last_owner_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  dec_err_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            gnt_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic [1:0]            pick;
  logic                  win_id;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic [IDX_W-1:0]      win_idx;
  logic                  latch, fin, fin_err;
  logic [DATA_WIDTH-1:0] fin_rdata;
  logic [NUM_SLAVES-1:0] sel_vec;
  logic                  ack_hit;
  logic [DATA_WIDTH-1:0] slv_rdata;
  logic                  in_access, in_resp;

  soc_bus_rr_arbiter u_rr (
    .req        ({m1_req_i, m0_req_i}),
    .last_owner (last_owner_q),
    .gnt        (pick)
  );

  always_comb begin
    win_id    = pick[1];
    win_we    = win_id ? m1_we_i    : m0_we_i;
    win_addr  = win_id ? m1_addr_i  : m0_addr_i;
    win_wdata = win_id ? m1_wdata_i : m0_wdata_i;
    win_idx   = win_addr[ADDR_WIDTH-1 -: IDX_W];
  end

  // Decode of the latched index; an out-of-range index selects nothing.
  always_comb begin
    sel_vec   = '0;
    slv_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_vec[i] = !dec_err_q && (idx_q == IDX_W'(i));
      if (sel_vec[i])
        slv_rdata = slv_rdata | s_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign ack_hit = |(s_ack_i & sel_vec);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch     = 1'b0;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_rdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|pick) begin
          latch   = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        // Ack wins over a timeout expiring in the same cycle.
        if (dec_err_q) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (ack_hit) begin
          fin       = 1'b1;
          fin_rdata = we_q ? '0 : slv_rdata;
        end else if (cnt_q >= CNT_LAST) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
        if (fin) state_d = ST_RESP;
      end
      ST_RESP: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= MST_CPU;
      last_owner_q <= MST_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      idx_q        <= '0;
      dec_err_q    <= 1'b0;
      cnt_q        <= '0;
      gnt_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= latch ? pick : 2'b00;
      if (latch) begin
        owner_q      <= win_id;
        last_owner_q <= win_id;
        we_q         <= win_we;
        addr_q       <= win_addr;
        wdata_q      <= win_wdata;
        idx_q        <= win_idx;
        dec_err_q    <= int'(win_idx) >= NUM_SLAVES;
      end
      if (fin) begin
        rdata_q <= fin_rdata;
        err_q   <= fin_err;
      end
    end
  end

  assign in_access = (state_q == ST_ACCESS);
  assign in_resp   = (state_q == ST_RESP);

  assign m0_gnt_o    = gnt_q[0];
  assign m1_gnt_o    = gnt_q[1];
  assign m0_rvalid_o = in_resp && (owner_q == MST_JTAG);
  assign m1_rvalid_o = in_resp && (owner_q == MST_CPU);
  assign m0_rdata_o  = m0_rvalid_o ? rdata_q : '0;
  assign m1_rdata_o  = m1_rvalid_o ? rdata_q : '0;
  assign m0_err_o    = m0_rvalid_o && err_q;
  assign m1_err_o    = m1_rvalid_o && err_q;

  assign s_sel_o   = in_access ? sel_vec : '0;
  assign s_we_o    = in_access && we_q;
  assign s_addr_o  = in_access ? addr_q  : '0;
  assign s_wdata_o = in_access ? wdata_q : '0;

endmodule
